pixel_stream_processor: RTL and testbench
=========================================

PIXEL_STREAM_PROCESSOR -- requirements
Module: pixel_stream_processor

Interface
REQ-001 Parameter CH_WIDTH, default 8, bits per colour channel.
REQ-002 Parameter NUM_CH, default 3, channels per pixel; channel 0 in the MSBs (R,G,B order).
REQ-003 Parameters IMAGE_WIDTH and IMAGE_HEIGHT, default 4 each; frame size N = IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-005 clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  frame start pulse; operation_select  in  3  op code; threshold_value  in  CH_WIDTH; brightness_value  in  CH_WIDTH.
REQ-007 s_valid  in  1; s_ready  out  1; s_data  in  NUM_CH*CH_WIDTH  input pixel stream.
REQ-008 m_valid  out  1; m_ready  in  1; m_data  out  NUM_CH*CH_WIDTH; m_last  out  1  output stream, last pixel flag.
REQ-009 busy  out  1; done  out  1  one-cycle pulse; pixel_count  out  clog2(N+1)  pixels accepted this frame.

Function
REQ-010 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when the output beat with m_last is accepted; DONE->IDLE unconditionally after one cycle.
REQ-011 On IDLE->RUN the block SHALL latch operation_select, threshold_value and brightness_value; changes during RUN have no effect.
REQ-012 start SHALL be ignored in RUN and DONE.
REQ-013 A beat is accepted on s_valid && s_ready; transferred on m_valid && m_ready.
REQ-014 s_ready = (state==RUN) && (pixel_count < N) && (!m_valid || m_ready); combinational from state and m_ready only.
REQ-015 Latency: one registered stage; accepted pixel appears on m_data the next cycle.
REQ-016 m_valid/m_data/m_last SHALL hold stable while m_valid && !m_ready.
REQ-017 m_last SHALL be high exactly on the output beat of the N-th accepted pixel.
REQ-018 Op 000 negative: each channel = (2^CH_WIDTH-1) - x.
REQ-019 Op 001 threshold: each channel = (x >= threshold) ? all-ones : 0.
REQ-020 Op 010 brighten: x + brightness, saturating at all-ones; computed at CH_WIDTH+1 bits.
REQ-021 Op 011 darken: x - brightness, saturating at 0.
REQ-022 Op 100 grayscale (see REQ-029); ops 101-111 pass-through unchanged.
REQ-023 busy high in RUN and DONE; done high only in DONE.
REQ-024 pixel_count increments per accepted beat, saturates at N, clears on IDLE->RUN, holds value in DONE/IDLE.
REQ-025 Simultaneous accept and transfer in the same cycle SHALL sustain one pixel per clock.

Reset
REQ-026 rst SHALL force state IDLE, s_ready 0, m_valid 0, m_last 0, m_data 0, done 0, busy 0, pixel_count 0, latched config 0.
REQ-027 rst mid-frame SHALL discard the in-flight pixel; no partial-frame done is produced.

Configuration
REQ-028 Macro PIXEL_STREAM_GRAYSCALE_EN selects the grayscale op.
REQ-029 Defined: op 100 with NUM_CH==3 outputs Y=(R+2G+B)>>2 (CH_WIDTH+2-bit sum) replicated to all channels; NUM_CH!=3 is pass-through. Undefined: op 100 is pass-through and no grayscale logic is synthesised.

Structure
REQ-030 Package pixel_stream_pkg holds op-code constants (OP_NEG, OP_THRESH, OP_BRIGHT, OP_DARK, OP_GRAY) and the FSM state encoding.
REQ-031 Per-channel arithmetic SHALL be one sub-module pixel_channel_op, instantiated NUM_CH times via generate; grayscale lives in the top.

Verification
REQ-032 Defaults, pixel i = {100+i, 50+i, 25+i}, op 000, m_ready=1: pixel 0 -> 0x9BCDE6, 16 beats, m_last on beat 15, done pulse 1 cycle after it.
REQ-033 Op 010, brightness 30, input 0xF0_10_E2 -> 0xFF_2E_FF; op 011, brightness 30, input 0x10_64_1E -> 0x00_46_00.
REQ-034 Op 001, threshold 100, same frame as REQ-032: pixel 0 -> 0xFF0000, pixel 15 -> 0xFF0000 (115,65,40).
REQ-035 m_ready toggled 1-of-3 cycles, random s_valid gaps: all 16 outputs correct and in order, m_data stable while stalled, pixel_count==16 at done.
REQ-036 rst asserted after 7 accepted pixels: next cycle all outputs at reset values; a new start then processes a full 16-pixel frame correctly.
REQ-037 With PIXEL_STREAM_GRAYSCALE_EN, op 100, input 0x644B32 -> 0x4B4B4B; without it -> 0x644B32.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream processor.
//   OP_*    : 3-bit operation codes decoded by the channel operators and the top
//   state_t : frame control FSM encoding (idle / run / done)
package pixel_stream_pkg;

  localparam logic [2:0] OP_NEG    = 3'b000;
  localparam logic [2:0] OP_THRESH = 3'b001;
  localparam logic [2:0] OP_BRIGHT = 3'b010;
  localparam logic [2:0] OP_DARK   = 3'b011;
  localparam logic [2:0] OP_GRAY   = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_stream_processor_channel_op.sv
// pixel_channel_op: combinational per-channel point operation.
//   op         : operation code (see pixel_stream_pkg)
//   x          : input channel value
//   threshold  : threshold for OP_THRESH
//   brightness : offset for OP_BRIGHT / OP_DARK
//   y          : result; grayscale and unused codes pass x through unchanged
module pixel_channel_op
  import pixel_stream_pkg::*;
#(
  parameter int unsigned CH_WIDTH = 8
) (
  input  logic [2:0]          op,
  input  logic [CH_WIDTH-1:0] x,
  input  logic [CH_WIDTH-1:0] threshold,
  input  logic [CH_WIDTH-1:0] brightness,
  output logic [CH_WIDTH-1:0] y
);

  // One extra bit so the carry out flags saturation.
  logic [CH_WIDTH:0] bright_sum;
  assign bright_sum = {1'b0, x} + {1'b0, brightness};

  always_comb begin
    y = x;
    case (op)
      OP_NEG:    y = ~x;
      OP_THRESH: y = (x >= threshold) ? '1 : '0;
      OP_BRIGHT: y = bright_sum[CH_WIDTH] ? '1 : bright_sum[CH_WIDTH-1:0];
      OP_DARK:   y = (x >= brightness) ? (x - brightness) : '0;
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/pixel_stream_processor.sv
// pixel_stream_processor: frame-based streaming pixel point-operation engine.
// Clock/reset : clk, rst (synchronous, active high)
// Control     : start, operation_select, threshold_value, brightness_value
//               (latched on frame start), busy, done (one-cycle pulse), pixel_count
// Input       : s_valid / s_ready / s_data (channel 0 in the MSBs)
// Output      : m_valid / m_ready / m_data / m_last, one registered stage
// Build option: define PIXEL_STREAM_GRAYSCALE_EN to enable the op 100 grayscale path;
//               otherwise op 100 is a pass-through and no grayscale logic exists.
module pixel_stream_processor
  import pixel_stream_pkg::*;
#(
  parameter int unsigned CH_WIDTH     = 8,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned IMAGE_WIDTH  = 4,
  parameter int unsigned IMAGE_HEIGHT = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [2:0]                                         operation_select,
  input  logic [CH_WIDTH-1:0]                                threshold_value,
  input  logic [CH_WIDTH-1:0]                                brightness_value,
  input  logic                                               s_valid,
  output logic                                               s_ready,
  input  logic [NUM_CH*CH_WIDTH-1:0]                         s_data,
  output logic                                               m_valid,
  input  logic                                               m_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]                         m_data,
  output logic                                               m_last,
  output logic                                               busy,
  output logic                                               done,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0]      pixel_count
);

  localparam int unsigned DataW    = NUM_CH * CH_WIDTH;
  localparam int unsigned FrameLen = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] FrameLenCnt = CntW'(FrameLen);
  localparam logic [CntW-1:0] LastIdx     = CntW'(FrameLen - 1);

  state_t state_q, state_d;

  logic [2:0]          op_q;
  logic [CH_WIDTH-1:0] thresh_q;
  logic [CH_WIDTH-1:0] bright_q;

  logic             accept;
  logic             xfer;
  logic [DataW-1:0] chan_result;
  logic [DataW-1:0] pix_result;

  // Output register is free when empty or being drained this cycle.
  assign s_ready = (state_q == StRun) && (pixel_count < FrameLenCnt) && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign xfer    = m_valid && m_ready;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (xfer && m_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      thresh_q    <= '0;
      bright_q    <= '0;
      pixel_count <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == StIdle && start) begin
        op_q        <= operation_select;
        thresh_q    <= threshold_value;
        bright_q    <= brightness_value;
        pixel_count <= '0;
      end else if (accept) begin
        pixel_count <= pixel_count + 1'b1;
      end

      // A new accept always refills the stage, even when it drains in the same cycle.
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= pix_result;
        m_last  <= (pixel_count == LastIdx);
      end else if (xfer) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pixel_channel_op #(
      .CH_WIDTH(CH_WIDTH)
    ) u_op (
      .op        (op_q),
      .x         (s_data[DataW-1-c*CH_WIDTH -: CH_WIDTH]),
      .threshold (thresh_q),
      .brightness(bright_q),
      .y         (chan_result[DataW-1-c*CH_WIDTH -: CH_WIDTH])
    );
  end

`ifdef PIXEL_STREAM_GRAYSCALE_EN
  if (NUM_CH == 3) begin : g_gray
    // R + 2G + B fits in CH_WIDTH+2 bits; dropping two LSBs divides by 4.
    logic [CH_WIDTH+1:0] luma_sum;
    logic [CH_WIDTH-1:0] luma;
    assign luma_sum = {2'b00, s_data[3*CH_WIDTH-1 -: CH_WIDTH]}
                    + {1'b0, s_data[2*CH_WIDTH-1 -: CH_WIDTH], 1'b0}
                    + {2'b00, s_data[CH_WIDTH-1:0]};
    assign luma       = luma_sum[CH_WIDTH+1:2];
    assign pix_result = (op_q == OP_GRAY) ? {NUM_CH{luma}} : chan_result;
  end else begin : g_no_gray
    assign pix_result = chan_result;
  end
`else
  assign pix_result = chan_result;
`endif

endmodule

// File: tb/tb_pixel_stream_processor.sv
// Self-checking bench for pixel_stream_processor (default parameters, 4x4 RGB888 frame).
// Define PIXEL_STREAM_GRAYSCALE_EN consistently for bench and RTL.
module tb_pixel_stream_processor;

  localparam int NPix = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  operation_select;
  logic [7:0]  threshold_value;
  logic [7:0]  brightness_value;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [4:0]  pixel_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] pix [NPix];
  logic [23:0] first_out;
  logic [23:0] last_out;

  always #5 clk = ~clk;

  pixel_stream_processor dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .operation_select(operation_select),
    .threshold_value (threshold_value),
    .brightness_value(brightness_value),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .busy            (busy),
    .done            (done),
    .pixel_count     (pixel_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on each channel.
  function automatic logic [23:0] model(input int op, input int th, input int br,
                                        input logic [23:0] p);
    int c [3];
    int r [3];
    int y;
    for (int i = 0; i < 3; i++) c[i] = int'(p[23-8*i -: 8]);
    y = (c[0] + 2 * c[1] + c[2]) / 4;
    for (int i = 0; i < 3; i++) begin
      case (op)
        0:       r[i] = 255 - c[i];
        1:       r[i] = (c[i] >= th) ? 255 : 0;
        2:       r[i] = (c[i] + br > 255) ? 255 : c[i] + br;
        3:       r[i] = (c[i] - br < 0) ? 0 : c[i] - br;
`ifdef PIXEL_STREAM_GRAYSCALE_EN
        4:       r[i] = y;
`endif
        default: r[i] = c[i];
      endcase
    end
    return {8'(r[0]), 8'(r[1]), 8'(r[2])};
  endfunction

  task automatic default_frame();
    for (int i = 0; i < NPix; i++) pix[i] = {8'(100 + i), 8'(50 + i), 8'(25 + i)};
  endtask

  task automatic random_frame();
    for (int i = 0; i < NPix; i++) pix[i] = 24'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".s_ready"}, s_ready, 0);
    check({tag, ".m_valid"}, m_valid, 0);
    check({tag, ".m_last"}, m_last, 0);
    check({tag, ".m_data"}, m_data, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".pixel_count"}, pixel_count, 0);
  endtask

  // Runs one frame; abort_at > 0 returns right after that many pixels are committed.
  task automatic run_frame(input string tag, input int op, input int th, input int br,
                           input bit stall, input bit gaps, input int abort_at);
    int in_idx = 0;
    int out_idx = 0;
    int last_cyc = -10;
    bit held_v = 0;
    bit finished = 0;
    logic [23:0] held_d;
    logic held_l;
    @(negedge clk);
    start = 1'b1;
    operation_select = 3'(op);
    threshold_value = 8'(th);
    brightness_value = 8'(br);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      // Config inputs and start are noise from here on.
      operation_select = 3'($urandom);
      threshold_value = 8'($urandom);
      brightness_value = 8'($urandom);
      start = ($urandom_range(0, 4) == 0);
      s_valid = (in_idx < NPix) && (!gaps || $urandom_range(0, 2) != 0);
      s_data = s_valid ? pix[in_idx] : 24'($urandom);
      m_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      if (held_v) begin
        check({tag, ".stall_valid"}, m_valid, 1);
        check({tag, ".stall_data"}, m_data, held_d);
        check({tag, ".stall_last"}, m_last, held_l);
      end
      if (done) begin
        check({tag, ".done_timing"}, cyc, last_cyc + 1);
        check({tag, ".beats"}, out_idx, NPix);
        check({tag, ".count_at_done"}, pixel_count, NPix);
        finished = 1;
        break;
      end
      check({tag, ".busy"}, busy, 1);
      check({tag, ".count"}, pixel_count, in_idx);
      if (m_valid && m_ready) begin
        check({tag, ".data"}, m_data, model(op, th, br, pix[out_idx]));
        check({tag, ".last"}, m_last, (out_idx == NPix - 1));
        if (out_idx == 0) first_out = m_data;
        if (out_idx == NPix - 1) begin
          last_out = m_data;
          last_cyc = cyc;
        end
        out_idx++;
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      if (s_valid && s_ready) in_idx++;
      if (abort_at > 0 && in_idx == abort_at) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    if (!finished) check({tag, ".timeout"}, 0, 1);
    if (abort_at == 0) begin
      @(negedge clk);
      #1;
      check({tag, ".done_pulse"}, done, 0);
      check({tag, ".idle"}, busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    operation_select = 3'd0;
    threshold_value = 8'd0;
    brightness_value = 8'd0;
    s_valid = 1'b0;
    s_data = 24'd0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    default_frame();
    run_frame("neg", 0, 0, 0, 0, 0, 0);
    check("neg.pixel0", first_out, 24'h9BCDE6);

    random_frame();
    pix[0] = 24'hF010E2;
    run_frame("bright", 2, 0, 30, 0, 0, 0);
    check("bright.pixel0", first_out, 24'hFF2EFF);

    random_frame();
    pix[0] = 24'h10641E;
    run_frame("dark", 3, 0, 30, 0, 1, 0);
    check("dark.pixel0", first_out, 24'h004600);

    default_frame();
    run_frame("thresh", 1, 100, 0, 0, 0, 0);
    check("thresh.pixel0", first_out, 24'hFF0000);
    check("thresh.pixel15", last_out, 24'hFF0000);

    random_frame();
    run_frame("stall", $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
              1, 1, 0);

    default_frame();
    run_frame("abort", 0, 0, 0, 1, 1, 7);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("midrst.no_done", done, 0);
    end
    run_frame("after_rst", 0, 0, 0, 1, 1, 0);
    check("after_rst.pixel0", first_out, 24'h9BCDE6);

    random_frame();
    pix[0] = 24'h644B32;
    run_frame("gray", 4, 0, 0, 0, 0, 0);
`ifdef PIXEL_STREAM_GRAYSCALE_EN
    check("gray.pixel0", first_out, 24'h4B4B4B);
`else
    check("gray.pixel0", first_out, 24'h644B32);
`endif

    for (int f = 0; f < 4; f++) begin
      random_frame();
      run_frame("rand", $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                1'($urandom), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
